// File: rtl/wb_master_message_queue.sv
// wb_master_message_queue: single-message buffer between an upstream word
// stream and a Wishbone master. Holds one header plus up to
// `MAX_BURST_LENGHT payload words, requests the bus once a complete message
// is held, and supports replay on retry.
// Optional feature: define MASTER_QUEUE_RETRY_LIMIT_EN to discard a message
// after RETRY_LIMIT retries (drop_o pulses); otherwise retries are unlimited.

`ifndef MAX_BURST_LENGHT
`define MAX_BURST_LENGHT 8
`endif
`ifndef BUS_ADDRESS_WIDTH
`define BUS_ADDRESS_WIDTH 32
`endif
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 32
`endif
`ifndef GRANULARITY
`define GRANULARITY 8
`endif

module wb_master_message_queue #(
  parameter int unsigned N_BITS_BURST_LENGHT = $clog2(`MAX_BURST_LENGHT),
  parameter int unsigned RETRY_LIMIT         = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       wr_valid_i,
  output logic                                       wr_ready_o,
  input  logic                                       wr_head_i,
  input  logic [`BUS_ADDRESS_WIDTH-1:0]              wr_address_i,
  input  logic [`BUS_DATA_WIDTH/`GRANULARITY-1:0]    wr_sel_i,
  input  logic                                       wr_transaction_type_i,
  input  logic [N_BITS_BURST_LENGHT-1:0]             wr_burst_lenght_i,
  input  logic [`BUS_DATA_WIDTH-1:0]                 wr_data_i,
  output logic                                       r_bus_arbitration_o,
  output logic [`BUS_ADDRESS_WIDTH-1:0]              address_o,
  output logic [`BUS_DATA_WIDTH/`GRANULARITY-1:0]    sel_o,
  output logic                                       transaction_type_o,
  output logic [N_BITS_BURST_LENGHT-1:0]             burst_lenght_o,
  output logic [`BUS_DATA_WIDTH-1:0]                 data_o,
  input  logic                                       next_data_i,
  input  logic                                       message_transmitted_i,
  input  logic                                       retry_i,
  output logic                                       drop_o
);

  localparam int unsigned NB    = N_BITS_BURST_LENGHT;
  localparam int unsigned DEPTH = `MAX_BURST_LENGHT;
  localparam int unsigned IW    = $clog2(DEPTH);
  localparam logic [NB-1:0] BL_MAX = NB'(DEPTH - 1);
  localparam logic [NB-1:0] BL_ONE = NB'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    REQ  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [`BUS_ADDRESS_WIDTH-1:0]           address_q, address_d;
  logic [`BUS_DATA_WIDTH/`GRANULARITY-1:0] sel_q, sel_d;
  logic                                    type_q, type_d;
  logic [NB-1:0]                           bl_q, bl_d;
  logic [NB-1:0]                           wr_cnt_q, wr_cnt_d;
  logic [NB-1:0]                           rd_ptr_q, rd_ptr_d;
  logic                                    arb_q, arb_d;
  logic                                    ram_we;
  logic                                    wr_fire;

  logic [`BUS_DATA_WIDTH-1:0] ram [DEPTH];

  // Oversized burst lengths are clamped to the last RAM index.
  function automatic logic [NB-1:0] sat_len(input logic [NB-1:0] len);
    if (32'(len) > 32'(DEPTH - 1)) return BL_MAX;
    return len;
  endfunction

  assign wr_ready_o          = (state_q != REQ);
  assign wr_fire             = wr_valid_i & wr_ready_o;
  assign r_bus_arbitration_o = arb_q;
  assign address_o           = address_q;
  assign sel_o               = sel_q;
  assign transaction_type_o  = type_q;
  assign burst_lenght_o      = bl_q;
  assign data_o              = ram[rd_ptr_q[IW-1:0]];

`ifdef MASTER_QUEUE_RETRY_LIMIT_EN
  localparam int unsigned RW = $clog2(RETRY_LIMIT + 1);
  logic [RW-1:0] retry_cnt_q, retry_cnt_d;
  logic          drop_q, drop_d;
  assign drop_o = drop_q;
`else
  logic unused_retry_limit;
  assign unused_retry_limit = (RETRY_LIMIT != 0);
  assign drop_o = 1'b0;
`endif

  // Next-state, header latch, pointer and bus-request computation.
  always_comb begin
    state_d   = state_q;
    address_d = address_q;
    sel_d     = sel_q;
    type_d    = type_q;
    bl_d      = bl_q;
    wr_cnt_d  = wr_cnt_q;
    rd_ptr_d  = rd_ptr_q;
    arb_d     = 1'b0;
    ram_we    = 1'b0;
`ifdef MASTER_QUEUE_RETRY_LIMIT_EN
    retry_cnt_d = retry_cnt_q;
    drop_d      = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (wr_fire && wr_head_i) begin
          address_d = wr_address_i;
          sel_d     = wr_sel_i;
          type_d    = wr_transaction_type_i;
          bl_d      = sat_len(wr_burst_lenght_i);
          wr_cnt_d  = '0;
          rd_ptr_d  = '0;
          if (wr_transaction_type_i) begin
            state_d = LOAD;
          end else begin
            state_d = REQ;
            arb_d   = 1'b1;
          end
        end
      end
      LOAD: begin
        if (wr_fire) begin
          ram_we   = 1'b1;
          wr_cnt_d = wr_cnt_q + BL_ONE;
          if (wr_cnt_q == bl_q) begin
            state_d  = REQ;
            arb_d    = 1'b1;
            rd_ptr_d = '0;
          end
        end
      end
      REQ: begin
        arb_d = 1'b1;
        if (message_transmitted_i) begin
          state_d = IDLE;
          arb_d   = 1'b0;
`ifdef MASTER_QUEUE_RETRY_LIMIT_EN
          retry_cnt_d = '0;
`endif
        end else if (retry_i) begin
          // Request is withdrawn for one cycle so the master re-arbitrates.
          rd_ptr_d = '0;
          arb_d    = 1'b0;
`ifdef MASTER_QUEUE_RETRY_LIMIT_EN
          if (32'(retry_cnt_q) + 32'd1 == 32'(RETRY_LIMIT)) begin
            state_d     = IDLE;
            drop_d      = 1'b1;
            retry_cnt_d = '0;
          end else begin
            retry_cnt_d = retry_cnt_q + RW'(1);
          end
`endif
        end else if (next_data_i) begin
          if (rd_ptr_q != bl_q) rd_ptr_d = rd_ptr_q + BL_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and header registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      address_q <= '0;
      sel_q     <= '0;
      type_q    <= 1'b0;
      bl_q      <= '0;
      wr_cnt_q  <= '0;
      rd_ptr_q  <= '0;
      arb_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      address_q <= address_d;
      sel_q     <= sel_d;
      type_q    <= type_d;
      bl_q      <= bl_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      arb_q     <= arb_d;
    end
  end

`ifdef MASTER_QUEUE_RETRY_LIMIT_EN
  // Retry counter and drop pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      retry_cnt_q <= '0;
      drop_q      <= 1'b0;
    end else begin
      retry_cnt_q <= retry_cnt_d;
      drop_q      <= drop_d;
    end
  end
`endif

  // Payload RAM; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram[wr_cnt_q[IW-1:0]] <= wr_data_i;
  end

endmodule

// File: tb/tb_wb_master_message_queue.sv
// Directed, table-driven bench for wb_master_message_queue.
`ifndef MAX_BURST_LENGHT
`define MAX_BURST_LENGHT 8
`endif
`ifndef BUS_ADDRESS_WIDTH
`define BUS_ADDRESS_WIDTH 32
`endif
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 32
`endif
`ifndef GRANULARITY
`define GRANULARITY 8
`endif

module tb_wb_master_message_queue;

  localparam int unsigned NB = $clog2(`MAX_BURST_LENGHT);

  logic clk = 1'b0;
  logic rst;
  logic wr_valid, wr_ready, wr_head, wr_type;
  logic [`BUS_ADDRESS_WIDTH-1:0] wr_addr;
  logic [`BUS_DATA_WIDTH/`GRANULARITY-1:0] wr_sel;
  logic [NB-1:0] wr_bl;
  logic [`BUS_DATA_WIDTH-1:0] wr_data;
  logic arb;
  logic [`BUS_ADDRESS_WIDTH-1:0] addr_o;
  logic [`BUS_DATA_WIDTH/`GRANULARITY-1:0] sel_o;
  logic type_o;
  logic [NB-1:0] bl_o;
  logic [`BUS_DATA_WIDTH-1:0] data_o;
  logic nxt, trans, retry, drop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_master_message_queue #(.RETRY_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_head_i(wr_head),
    .wr_address_i(wr_addr), .wr_sel_i(wr_sel), .wr_transaction_type_i(wr_type),
    .wr_burst_lenght_i(wr_bl), .wr_data_i(wr_data),
    .r_bus_arbitration_o(arb), .address_o(addr_o), .sel_o(sel_o),
    .transaction_type_o(type_o), .burst_lenght_o(bl_o), .data_o(data_o),
    .next_data_i(nxt), .message_transmitted_i(trans), .retry_i(retry),
    .drop_o(drop)
  );

  typedef struct {
    logic        valid, head, typ;
    logic [31:0] addr, data;
    logic [2:0]  bl;
    logic        nxt, trans, retry;
    logic        e_ready, e_arb;
    logic [31:0] e_addr;
    logic        chk_data;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, h, input logic [31:0] a, input logic t,
                     input logic [2:0] b, input logic [31:0] d,
                     input logic n, tr, r, input logic er, ea,
                     input logic [31:0] eaddr, input logic cd,
                     input logic [31:0] ed);
    vec_t x;
    x.valid = v; x.head = h; x.addr = a; x.typ = t; x.bl = b; x.data = d;
    x.nxt = n; x.trans = tr; x.retry = r; x.e_ready = er; x.e_arb = ea;
    x.e_addr = eaddr; x.chk_data = cd; x.e_data = ed;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, h, input logic [31:0] a, input logic t,
                       input logic [2:0] b, input logic [31:0] d,
                       input logic n, tr, r);
    wr_valid = v; wr_head = h; wr_addr = a; wr_type = t; wr_bl = b;
    wr_data = d; nxt = n; trans = tr; retry = r;
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    wr_sel = 4'hF;
    idle_in();
    step();
    step();
    chk("reset_ready", wr_ready, 1);
    chk("reset_arb", arb, 0);
    chk("reset_drop", drop, 0);
    chk("reset_addr", addr_o, 0);
    chk("reset_sel", sel_o, 0);
    chk("reset_bl", bl_o, 0);
    rst = 1'b0;

    // Read message, write message with replay, transmit/retry collision.
    add(1,1,'h100,0,0,0,       0,0,0, 0,1,'h100,0,0);
    add(0,0,0,0,0,0,           0,1,0, 1,0,'h100,0,0);
    add(1,1,'h200,1,5,0,       0,0,0, 1,0,'h200,0,0);
    add(1,0,0,0,0,'hA0,        0,0,0, 1,0,'h200,0,0);
    add(1,0,0,0,0,'hA1,        0,0,0, 1,0,'h200,0,0);
    add(1,1,'hDEAD,0,0,'hA2,   0,0,0, 1,0,'h200,0,0);
    add(1,0,0,0,0,'hA3,        0,0,0, 1,0,'h200,0,0);
    add(1,0,0,0,0,'hA4,        0,0,0, 1,0,'h200,0,0);
    add(1,0,0,0,0,'hA5,        0,0,0, 0,1,'h200,1,'hA0);
    add(1,0,0,0,0,'hFF,        0,0,0, 0,1,'h200,1,'hA0);
    add(0,0,0,0,0,0,           1,0,0, 0,1,'h200,1,'hA1);
    add(0,0,0,0,0,0,           1,0,0, 0,1,'h200,1,'hA2);
    add(0,0,0,0,0,0,           1,0,0, 0,1,'h200,1,'hA3);
    add(0,0,0,0,0,0,           0,0,1, 0,0,'h200,1,'hA0);
    add(0,0,0,0,0,0,           0,0,0, 0,1,'h200,1,'hA0);
    add(0,0,0,0,0,0,           1,0,0, 0,1,'h200,1,'hA1);
    add(0,0,0,0,0,0,           1,0,0, 0,1,'h200,1,'hA2);
    add(0,0,0,0,0,0,           1,0,0, 0,1,'h200,1,'hA3);
    add(0,0,0,0,0,0,           1,0,0, 0,1,'h200,1,'hA4);
    add(0,0,0,0,0,0,           1,0,0, 0,1,'h200,1,'hA5);
    add(0,0,0,0,0,0,           1,0,0, 0,1,'h200,1,'hA5);
    add(0,0,0,0,0,0,           0,0,0, 0,1,'h200,1,'hA5);
    add(0,0,0,0,0,0,           1,1,1, 1,0,'h200,0,0);
    add(1,1,'h300,0,0,0,       0,0,0, 0,1,'h300,0,0);
    add(0,0,0,0,0,0,           0,1,0, 1,0,'h300,0,0);
    add(1,0,'h999,0,0,'h55,    0,0,0, 1,0,'h300,0,0);
    add(1,1,'h400,0,0,0,       0,0,0, 0,1,'h400,0,0);
    add(0,0,0,0,0,0,           0,1,0, 1,0,'h400,0,0);

    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].head, vecs[i].addr, vecs[i].typ,
            vecs[i].bl, vecs[i].data, vecs[i].nxt, vecs[i].trans, vecs[i].retry);
      step();
      chk($sformatf("v%0d_ready", i), wr_ready, vecs[i].e_ready);
      chk($sformatf("v%0d_arb", i), arb, vecs[i].e_arb);
      chk($sformatf("v%0d_addr", i), addr_o, vecs[i].e_addr);
      chk($sformatf("v%0d_drop", i), drop, 0);
      if (vecs[i].chk_data) chk($sformatf("v%0d_data", i), data_o, vecs[i].e_data);
    end

    // Repeated retries on a one-word write message.
    drive(1, 1, 'h500, 1, 0, 0, 0, 0, 0);
    step();
    drive(1, 0, 0, 0, 0, 'hB0, 0, 0, 0);
    step();
    chk("rt_arb", arb, 1);
    chk("rt_data", data_o, 'hB0);
`ifdef MASTER_QUEUE_RETRY_LIMIT_EN
    for (int r = 1; r <= 4; r++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      step();
      if (r == 4) begin
        chk("rt_drop_pulse", drop, 1);
        chk("rt_drop_ready", wr_ready, 1);
        chk("rt_drop_arb", arb, 0);
        idle_in();
        step();
        chk("rt_drop_clear", drop, 0);
        chk("rt_drop_idle", wr_ready, 1);
      end else begin
        chk($sformatf("rt%0d_arb_lo", r), arb, 0);
        chk($sformatf("rt%0d_drop", r), drop, 0);
        idle_in();
        step();
        chk($sformatf("rt%0d_arb_hi", r), arb, 1);
      end
    end
`else
    for (int r = 1; r <= 10; r++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      step();
      chk($sformatf("rt%0d_arb_lo", r), arb, 0);
      chk($sformatf("rt%0d_ready", r), wr_ready, 0);
      chk($sformatf("rt%0d_drop", r), drop, 0);
      idle_in();
      step();
      chk($sformatf("rt%0d_arb_hi", r), arb, 1);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step();
    chk("rt_done_ready", wr_ready, 1);
`endif

    // Reset in the middle of a load.
    idle_in();
    drive(1, 1, 'h600, 1, 5, 0, 0, 0, 0);
    step();
    chk("ld_type", type_o, 1);
    chk("ld_bl", bl_o, 5);
    chk("ld_sel", sel_o, 'hF);
    drive(1, 0, 0, 0, 0, 'hC0, 0, 0, 0);
    step();
    drive(1, 0, 0, 0, 0, 'hC1, 0, 0, 0);
    step();
    rst = 1'b1;
    drive(1, 0, 0, 0, 0, 'hC2, 0, 0, 0);
    step();
    rst = 1'b0;
    chk("mrst_ready", wr_ready, 1);
    chk("mrst_arb", arb, 0);
    chk("mrst_addr", addr_o, 0);
    chk("mrst_sel", sel_o, 0);
    chk("mrst_type", type_o, 0);
    chk("mrst_bl", bl_o, 0);
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 'h777, 0, 0, 'hD0 + k, 0, 0, 0);
      step();
      chk($sformatf("mrst_disc%0d_ready", k), wr_ready, 1);
      chk($sformatf("mrst_disc%0d_arb", k), arb, 0);
      chk($sformatf("mrst_disc%0d_addr", k), addr_o, 0);
    end
    drive(1, 1, 'h700, 0, 0, 0, 0, 0, 0);
    step();
    chk("post_rst_arb", arb, 1);
    chk("post_rst_addr", addr_o, 'h700);
    idle_in();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
